// File: rtl/coproc_host_bridge.sv
// Host command sequencer for the matrix coprocessor: collects a request frame, issues it, returns status + result.
// Optional BRIDGE_CHECKSUM_EN adds an XOR checksum byte to both the request frame and the response.
module coproc_host_bridge #(
  parameter int SETTLE_CYCLES = 2,
  parameter int DET_TIMEOUT   = 1024
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         host_valid,
  output logic         host_ready,
  input  logic [7:0]   host_data,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [7:0]   res_data,
  output logic [2:0]   cp_op_code,
  output logic [199:0] cp_matrix_a,
  output logic [199:0] cp_matrix_b,
  output logic [7:0]   cp_scalar,
  output logic         cp_start,
  input  logic [199:0] cp_result,
  input  logic         cp_overflow,
  input  logic         cp_done
);

`ifdef BRIDGE_CHECKSUM_EN
  localparam logic [5:0] RX_LAST = 6'd52;
  localparam logic [4:0] TX_LAST = 5'd26;
`else
  localparam logic [5:0] RX_LAST = 6'd51;
  localparam logic [4:0] TX_LAST = 5'd25;
`endif
  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);
  localparam logic [15:0] DET_LAST    = 16'(DET_TIMEOUT - 1);
  localparam logic [2:0]  OP_DET      = 3'b101;

  typedef enum logic [1:0] {ST_RX, ST_ISSUE, ST_WAIT, ST_TX} state_t;

  state_t       state_q, state_d;
  logic [5:0]   rx_cnt_q, rx_cnt_d;
  logic [4:0]   tx_idx_q, tx_idx_d;
  logic [15:0]  wait_cnt_q, wait_cnt_d;
  logic [2:0]   op_q, op_d;
  logic [7:0]   scalar_q, scalar_d;
  logic [199:0] mat_a_q, mat_a_d;
  logic [199:0] mat_b_q, mat_b_d;
  logic [199:0] result_q, result_d;
  logic         ovf_q, ovf_d;
  logic         tmo_q, tmo_d;
  logic         bad_op_q, bad_op_d;
  logic         ck_err_q, ck_err_d;
  logic         ck_bad_q, ck_bad_d;
  logic [7:0]   rx_xor_q, rx_xor_d;
  logic [7:0]   tx_xor_q, tx_xor_d;

  logic [4:0]   a_elem, b_elem, r_elem;
  logic         rx_fire, tx_fire, abort;
  logic [7:0]   status;

  assign host_ready  = (state_q == ST_RX);
  assign res_valid   = (state_q == ST_TX);
  assign rx_fire     = host_valid & host_ready;
  assign tx_fire     = res_valid & res_ready;
  // Reserved op codes and corrupted frames never reach the coprocessor.
  assign abort       = (op_q[2:1] == 2'b11) || ck_bad_q;
  assign cp_start    = (state_q == ST_ISSUE) && !abort;
  assign cp_op_code  = op_q;
  assign cp_scalar   = scalar_q;
  assign cp_matrix_a = mat_a_q;
  assign cp_matrix_b = mat_b_q;
  assign status      = {ovf_q, tmo_q, bad_op_q, ck_err_q, 1'b0, op_q};
  assign a_elem      = 5'(rx_cnt_q - 6'd2);
  assign b_elem      = 5'(rx_cnt_q - 6'd27);
  assign r_elem      = tx_idx_q - 5'd1;

  always_comb begin
    res_data = 8'h00;
    if (state_q == ST_TX) begin
      if (tx_idx_q == 5'd0)       res_data = status;
      else if (tx_idx_q <= 5'd25) res_data = result_q[{r_elem, 3'b000} +: 8];
      else                        res_data = tx_xor_q;
    end
  end

  always_comb begin
    state_d    = state_q;
    rx_cnt_d   = rx_cnt_q;
    tx_idx_d   = tx_idx_q;
    wait_cnt_d = wait_cnt_q;
    op_d       = op_q;
    scalar_d   = scalar_q;
    mat_a_d    = mat_a_q;
    mat_b_d    = mat_b_q;
    result_d   = result_q;
    ovf_d      = ovf_q;
    tmo_d      = tmo_q;
    bad_op_d   = bad_op_q;
    ck_err_d   = ck_err_q;
    ck_bad_d   = ck_bad_q;
    rx_xor_d   = rx_xor_q;
    tx_xor_d   = tx_xor_q;
    case (state_q)
      ST_RX: begin
        if (rx_fire) begin
          rx_xor_d = rx_xor_q ^ host_data;
          if (rx_cnt_q == 6'd0)       op_d = host_data[7:5];
          else if (rx_cnt_q == 6'd1)  scalar_d = host_data;
          else if (rx_cnt_q <= 6'd26) mat_a_d[{a_elem, 3'b000} +: 8] = host_data;
          else if (rx_cnt_q <= 6'd51) mat_b_d[{b_elem, 3'b000} +: 8] = host_data;
`ifdef BRIDGE_CHECKSUM_EN
          else                        ck_bad_d = (host_data != rx_xor_q);
`endif
          if (rx_cnt_q == RX_LAST) begin
            rx_cnt_d = 6'd0;
            state_d  = ST_ISSUE;
          end else begin
            rx_cnt_d = rx_cnt_q + 6'd1;
          end
        end
      end
      ST_ISSUE: begin
        ovf_d      = 1'b0;
        tmo_d      = 1'b0;
        bad_op_d   = (op_q[2:1] == 2'b11);
        ck_err_d   = ck_bad_q;
        ck_bad_d   = 1'b0;
        rx_xor_d   = 8'h00;
        tx_xor_d   = 8'h00;
        tx_idx_d   = 5'd0;
        wait_cnt_d = 16'd0;
        if (abort) begin
          result_d = '0;
          state_d  = ST_TX;
        end else begin
          state_d  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        wait_cnt_d = wait_cnt_q + 16'd1;
        if (op_q == OP_DET) begin
          // The first WAIT cycle's cp_done may be stale from the previous command.
          if (wait_cnt_q != 16'd0 && cp_done) begin
            result_d = cp_result;
            state_d  = ST_TX;
          end else if (wait_cnt_q == DET_LAST) begin
            result_d = cp_result;
            tmo_d    = 1'b1;
            state_d  = ST_TX;
          end
        end else if (wait_cnt_q == SETTLE_LAST) begin
          result_d = cp_result;
          ovf_d    = cp_overflow;
          state_d  = ST_TX;
        end
      end
      ST_TX: begin
        if (tx_fire) begin
          tx_xor_d = tx_xor_q ^ res_data;
          if (tx_idx_q == TX_LAST) state_d = ST_RX;
          else                     tx_idx_d = tx_idx_q + 5'd1;
        end
      end
      default: state_d = ST_RX;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_RX;
      rx_cnt_q   <= 6'd0;
      tx_idx_q   <= 5'd0;
      wait_cnt_q <= 16'd0;
      op_q       <= 3'd0;
      scalar_q   <= 8'h00;
      mat_a_q    <= '0;
      mat_b_q    <= '0;
      result_q   <= '0;
      ovf_q      <= 1'b0;
      tmo_q      <= 1'b0;
      bad_op_q   <= 1'b0;
      ck_err_q   <= 1'b0;
      ck_bad_q   <= 1'b0;
      rx_xor_q   <= 8'h00;
      tx_xor_q   <= 8'h00;
    end else begin
      state_q    <= state_d;
      rx_cnt_q   <= rx_cnt_d;
      tx_idx_q   <= tx_idx_d;
      wait_cnt_q <= wait_cnt_d;
      op_q       <= op_d;
      scalar_q   <= scalar_d;
      mat_a_q    <= mat_a_d;
      mat_b_q    <= mat_b_d;
      result_q   <= result_d;
      ovf_q      <= ovf_d;
      tmo_q      <= tmo_d;
      bad_op_q   <= bad_op_d;
      ck_err_q   <= ck_err_d;
      ck_bad_q   <= ck_bad_d;
      rx_xor_q   <= rx_xor_d;
      tx_xor_q   <= tx_xor_d;
    end
  end

endmodule

// File: tb/tb_coproc_host_bridge.sv
// Self-checking bench for coproc_host_bridge with a behavioural coprocessor stub and response model.
// Builds with or without BRIDGE_CHECKSUM_EN.
module tb_coproc_host_bridge;
  localparam int SETTLE = 2;
  localparam int DET_TO = 1024;
`ifdef BRIDGE_CHECKSUM_EN
  localparam int RESP_LEN = 27;
`else
  localparam int RESP_LEN = 26;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         host_valid = 1'b0;
  logic         host_ready;
  logic [7:0]   host_data = 8'h00;
  logic         res_valid;
  logic         res_ready = 1'b0;
  logic [7:0]   res_data;
  logic [2:0]   cp_op_code;
  logic [199:0] cp_matrix_a, cp_matrix_b;
  logic [7:0]   cp_scalar;
  logic         cp_start;
  logic [199:0] stub_result = '0;
  logic         stub_ovf = 1'b0;
  logic         done_en = 1'b0;
  logic         cp_done;
  int           done_delay = 40;

  int cyc = 0, since_q = 1000000, start_pulses = 0, start_cyc = 0;
  int checks = 0, errors = 0;

  logic [2:0]   fr_op = 3'd0;
  logic [7:0]   fr_scalar = 8'h00;
  logic [7:0]   fr_a [25];
  logic [7:0]   fr_b [25];
  logic [7:0]   ck_corrupt = 8'h00;
  logic [7:0]   resp [$];
  logic [7:0]   exp_q [$];
  int           accept_cyc = 0, first_valid_cyc = 0, start_before = 0;
  bit           hr_bad, data_moved, field_moved;
  logic [2:0]   seen_op;
  logic [7:0]   seen_scalar;
  logic [199:0] seen_a, seen_b;

  coproc_host_bridge #(.SETTLE_CYCLES(SETTLE), .DET_TIMEOUT(DET_TO)) dut (
    .clk(clk), .rst(rst),
    .host_valid(host_valid), .host_ready(host_ready), .host_data(host_data),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .cp_op_code(cp_op_code), .cp_matrix_a(cp_matrix_a), .cp_matrix_b(cp_matrix_b),
    .cp_scalar(cp_scalar), .cp_start(cp_start),
    .cp_result(stub_result), .cp_overflow(stub_ovf), .cp_done(cp_done)
  );

  always #5 clk = ~clk;

  // Coprocessor stub: counts start-high cycles and raises done a fixed delay after start.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (cp_start) begin
      since_q      <= 1;
      start_pulses <= start_pulses + 1;
      start_cyc    <= cyc;
    end else if (since_q < 1000000) begin
      since_q <= since_q + 1;
    end
  end
  assign cp_done = done_en && (since_q >= done_delay);

  function automatic logic [7:0] frame_byte(input int k);
    if (k == 0) return {fr_op, 5'b0};
    if (k == 1) return fr_scalar;
    if (k < 27) return fr_a[k-2];
    return fr_b[k-27];
  endfunction

  function automatic logic [199:0] pack(input logic [7:0] m [25]);
    logic [199:0] v = '0;
    for (int k = 0; k < 25; k++) v[8*k +: 8] = m[k];
    return v;
  endfunction

  function automatic logic [7:0] model_status(input logic [2:0] op, input bit ovf,
                                              input bit done_arrives, input bit ck_bad);
    bit bad = (op >= 3'd6);
    bit ran = !bad && !ck_bad;
    return {ran && (op < 3'd5) && ovf, ran && (op == 3'd5) && !done_arrives, bad, ck_bad, 1'b0, op};
  endfunction

  task automatic build_expected(input logic [7:0] st, input bit zero_res);
    logic [7:0] x = st;
    logic [7:0] e;
    exp_q.delete();
    exp_q.push_back(st);
    for (int k = 0; k < 25; k++) begin
      e = zero_res ? 8'h00 : stub_result[8*k +: 8];
      exp_q.push_back(e);
      x = x ^ e;
    end
    if (RESP_LEN == 27) exp_q.push_back(x);
  endtask

  task automatic fill_random();
    fr_scalar = 8'($urandom);
    for (int k = 0; k < 25; k++) begin
      fr_a[k] = 8'($urandom);
      fr_b[k] = 8'($urandom);
      stub_result[8*k +: 8] = 8'($urandom);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int guard = 0;
    if (gaps) begin
      host_valid = 1'b0;
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    host_valid = 1'b1;
    host_data  = b;
    forever begin
      @(negedge clk);
      if (host_ready) begin
        accept_cyc = cyc;
        @(posedge clk); #1;
        return;
      end
      @(posedge clk); #1;
      guard++;
      if (guard > 100) begin
        checks++; errors++;
        $display("FAIL send_timeout: host_ready stayed %b, want 1", host_ready);
        return;
      end
    end
  endtask

  task automatic send_frame(input bit gaps);
    logic [7:0] x = 8'h00;
    logic [7:0] b;
    for (int k = 0; k < 52; k++) begin
      b = frame_byte(k);
      x = x ^ b;
      send_byte(b, gaps);
    end
`ifdef BRIDGE_CHECKSUM_EN
    send_byte(x ^ ck_corrupt, gaps);
`endif
  endtask

  task automatic recv_response(input int mode);
    int guard = 0;
    bit held = 0;
    logic [7:0] held_data = 8'h00;
    resp.delete();
    first_valid_cyc = -1; hr_bad = 0; data_moved = 0; field_moved = 0;
    while (resp.size() < RESP_LEN && guard < 3000) begin
      case (mode)
        0:       res_ready = 1'b1;
        1:       res_ready = ((guard % 2) == 0);
        default: res_ready = 1'($urandom_range(0, 1));
      endcase
      @(negedge clk);
      if (host_ready) hr_bad = 1;
      if (res_valid) begin
        if (first_valid_cyc < 0) begin
          first_valid_cyc = cyc;
          seen_op = cp_op_code; seen_scalar = cp_scalar; seen_a = cp_matrix_a; seen_b = cp_matrix_b;
        end else if (cp_op_code !== seen_op || cp_scalar !== seen_scalar ||
                     cp_matrix_a !== seen_a || cp_matrix_b !== seen_b) begin
          field_moved = 1;
        end
        if (held && res_data !== held_data) data_moved = 1;
        held = !res_ready;
        held_data = res_data;
        if (res_ready) resp.push_back(res_data);
      end
      @(posedge clk); #1;
      guard++;
    end
    res_ready  = 1'b0;
    host_valid = 1'b0;
    checks++;
    if (resp.size() != RESP_LEN) begin
      errors++;
      $display("FAIL recv_count: got %0d bytes want %0d", resp.size(), RESP_LEN);
    end
  endtask

  task automatic run_frame(input bit gaps, input int mode, input bit junk);
    start_before = start_pulses;
    send_frame(gaps);
    host_valid = junk;
    host_data  = 8'($urandom);
    recv_response(mode);
  endtask

  task automatic test_reset();
    rst = 1'b1; host_valid = 1'b0; res_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (host_ready !== 1'b1) begin errors++; $display("FAIL reset_host_ready: got %b want 1", host_ready); end
    checks++; if (res_valid !== 1'b0 || res_data !== 8'h00) begin errors++; $display("FAIL reset_res: got valid %b data %h want 0 00", res_valid, res_data); end
    checks++; if (cp_start !== 1'b0 || cp_op_code !== 3'd0 || cp_scalar !== 8'h00) begin errors++; $display("FAIL reset_cp_ctrl: got start %b op %0d scalar %h want 0", cp_start, cp_op_code, cp_scalar); end
    checks++; if (cp_matrix_a !== '0 || cp_matrix_b !== '0) begin errors++; $display("FAIL reset_cp_mat: got a %h b %h want 0", cp_matrix_a, cp_matrix_b); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    fr_op = 3'd0; fr_scalar = 8'h07; stub_ovf = 1'b0; done_en = 1'b0; ck_corrupt = 8'h00;
    for (int k = 0; k < 25; k++) begin fr_a[k] = 8'h01; fr_b[k] = 8'h02; stub_result[8*k +: 8] = 8'h03; end
    run_frame(0, 0, 0);
    build_expected(model_status(fr_op, stub_ovf, 1, 0), 0);
    for (int k = 0; k < RESP_LEN; k++) begin
      checks++;
      if (resp[k] !== exp_q[k]) begin errors++; $display("FAIL basic_byte%0d: got %h want %h", k, resp[k], exp_q[k]); end
    end
    checks++; if (first_valid_cyc - accept_cyc != 2 + SETTLE) begin errors++; $display("FAIL basic_latency: got %0d want %0d", first_valid_cyc - accept_cyc, 2 + SETTLE); end
    checks++; if (start_pulses - start_before != 1) begin errors++; $display("FAIL basic_start: got %0d pulses want 1", start_pulses - start_before); end
    checks++; if (seen_a !== pack(fr_a) || seen_b !== pack(fr_b)) begin errors++; $display("FAIL basic_matrix: got a %h b %h", seen_a, seen_b); end
    checks++; if (seen_scalar !== fr_scalar || seen_op !== fr_op) begin errors++; $display("FAIL basic_scalar_op: got %h/%0d want %h/%0d", seen_scalar, seen_op, fr_scalar, fr_op); end
  endtask

  task automatic test_overflow();
    fr_op = 3'd0; fill_random(); stub_ovf = 1'b1; done_en = 1'b0;
    run_frame(0, 0, 0);
    checks++; if (resp[0] !== 8'h80) begin errors++; $display("FAIL ovf_status: got %h want 80", resp[0]); end
    checks++; if (start_pulses - start_before != 1) begin errors++; $display("FAIL ovf_start_width: got %0d high cycles want 1", start_pulses - start_before); end
    stub_ovf = 1'b0;
  endtask

  task automatic test_det();
    fr_op = 3'd5; fill_random(); stub_result = 200'h1234; stub_ovf = 1'b1; done_en = 1'b1; done_delay = 40;
    run_frame(0, 0, 0);
    build_expected(8'h05, 0);
    for (int k = 0; k < RESP_LEN; k++) begin
      checks++;
      if (resp[k] !== exp_q[k]) begin errors++; $display("FAIL det_byte%0d: got %h want %h", k, resp[k], exp_q[k]); end
    end
    checks++; if (first_valid_cyc - start_cyc != 41) begin errors++; $display("FAIL det_latency: got %0d want 41", first_valid_cyc - start_cyc); end
    stub_ovf = 1'b0; done_en = 1'b0;
  endtask

  task automatic test_det_timeout();
    fr_op = 3'd5; fill_random(); done_en = 1'b0;
    run_frame(0, 0, 0);
    build_expected(8'h45, 0);
    for (int k = 0; k < RESP_LEN; k++) begin
      checks++;
      if (resp[k] !== exp_q[k]) begin errors++; $display("FAIL tmo_byte%0d: got %h want %h", k, resp[k], exp_q[k]); end
    end
    checks++; if (first_valid_cyc - start_cyc != DET_TO + 1) begin errors++; $display("FAIL tmo_latency: got %0d want %0d", first_valid_cyc - start_cyc, DET_TO + 1); end
  endtask

  task automatic test_random();
    int want_lat;
    for (int f = 0; f < 8; f++) begin
      fr_op = 3'($urandom_range(0, 7)); fill_random();
      stub_ovf = 1'($urandom_range(0, 1));
      done_en = (fr_op == 3'd5);
      done_delay = $urandom_range(1, 30);
      run_frame(1, (f % 2) + 1, 1);
      build_expected(model_status(fr_op, stub_ovf, 1, 0), fr_op >= 3'd6);
      for (int k = 0; k < RESP_LEN; k++) begin
        checks++;
        if (resp[k] !== exp_q[k]) begin errors++; $display("FAIL rand%0d_byte%0d: got %h want %h (op %0d)", f, k, resp[k], exp_q[k], fr_op); end
      end
      checks++; if (hr_bad || data_moved || field_moved) begin errors++; $display("FAIL rand%0d_stability: host_ready_high %0d data_moved %0d field_moved %0d want 0 0 0", f, hr_bad, data_moved, field_moved); end
      checks++; if (start_pulses - start_before != ((fr_op < 3'd6) ? 1 : 0)) begin errors++; $display("FAIL rand%0d_start: got %0d pulses (op %0d)", f, start_pulses - start_before, fr_op); end
      if (fr_op < 3'd6) begin
        checks++; if (seen_a !== pack(fr_a) || seen_b !== pack(fr_b) || seen_scalar !== fr_scalar) begin errors++; $display("FAIL rand%0d_fields: operand outputs differ from frame", f); end
      end
      if (fr_op < 3'd5) begin
        checks++; if (first_valid_cyc - accept_cyc != 2 + SETTLE) begin errors++; $display("FAIL rand%0d_latency: got %0d want %0d", f, first_valid_cyc - accept_cyc, 2 + SETTLE); end
      end else if (fr_op == 3'd5) begin
        want_lat = ((done_delay < 2) ? 2 : done_delay) + 1;
        checks++; if (first_valid_cyc - start_cyc != want_lat) begin errors++; $display("FAIL rand%0d_det_latency: got %0d want %0d", f, first_valid_cyc - start_cyc, want_lat); end
      end
    end
    done_en = 1'b0; stub_ovf = 1'b0;
  endtask

  task automatic test_abort_bad_op();
    fr_op = 3'd3; fill_random();
    for (int k = 0; k < 30; k++) send_byte(frame_byte(k), 0);
    host_valid = 1'b0;
    rst = 1'b1;
    #1;
    checks++; if (cp_matrix_a !== '0 || cp_op_code !== 3'd0 || cp_scalar !== 8'h00) begin errors++; $display("FAIL abort_async_clear: got op %0d scalar %h a %h want 0", cp_op_code, cp_scalar, cp_matrix_a); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    fr_op = 3'd7; fill_random();
    run_frame(1, 0, 1);
    build_expected(8'h27, 1);
    for (int k = 0; k < RESP_LEN; k++) begin
      checks++;
      if (resp[k] !== exp_q[k]) begin errors++; $display("FAIL badop_byte%0d: got %h want %h", k, resp[k], exp_q[k]); end
    end
    checks++; if (start_pulses != start_before) begin errors++; $display("FAIL badop_start: got %0d pulses want 0", start_pulses - start_before); end
  endtask

`ifdef BRIDGE_CHECKSUM_EN
  task automatic test_bad_checksum();
    fr_op = 3'd2; fill_random(); ck_corrupt = 8'h5a;
    run_frame(0, 1, 0);
    build_expected(8'h12, 1);
    for (int k = 0; k < RESP_LEN; k++) begin
      checks++;
      if (resp[k] !== exp_q[k]) begin errors++; $display("FAIL cksum_byte%0d: got %h want %h", k, resp[k], exp_q[k]); end
    end
    checks++; if (start_pulses != start_before) begin errors++; $display("FAIL cksum_start: got %0d pulses want 0", start_pulses - start_before); end
    ck_corrupt = 8'h00;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_det();
    test_det_timeout();
    test_random();
    test_abort_bad_op();
`ifdef BRIDGE_CHECKSUM_EN
    test_bad_checksum();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
